// File: rtl/matbuf_pkg.sv
// Shared types and helpers for the matrix_buf store.
//   state_t : control FSM states (idle, zero-clear sweep, dump stream)
//   lin_idx : row-major linear cell index, row*cols + col
package matbuf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DUMP  = 2'd2
   } state_t;

   function automatic int unsigned lin_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/matbuf_skid.sv
// One-entry valid/ready skid buffer with a registered output stage.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      upstream handshake (in_ready registered: !skid full)
//   in_data [W]            upstream payload
//   out_valid/out_ready    downstream handshake
//   out_data [W]           downstream payload, held while out_valid & !out_ready
module matbuf_skid #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         skid_v;
   logic [W-1:0] skid_q;

   assign in_ready = !skid_v;

   // Output register refills from the skid slot first so order is preserved.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_v    <= 1'b0;
         skid_q    <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_v) begin
            out_valid <= 1'b1;
            out_data  <= skid_q;
            skid_v    <= 1'b0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end else if (in_valid && !skid_v) begin
         skid_v <= 1'b1;
         skid_q <= in_data;
      end
   end

endmodule

// File: rtl/matrix_buf.sv
// ROWS x COLS word store with random write/read ports, a zero-clear sweep
// and a handshaked dump stream (row-major, optionally column-major).
// Optional feature macro: MATBUF_COLMAJOR_EN adds input dump_colmajor,
// sampled at dump_start; 1 selects column-major dump order.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   wr_en, wr_row, wr_col, wr_data      write port (IDLE and DUMP only)
//   rd_en, rd_row, rd_col               random read request (IDLE only)
//   rd_data, rd_valid                   read word, valid pulse one cycle later
//   clr_start, dump_start               sweep start pulses (ignored when busy)
//   busy                                FSM not idle
//   dump_valid, dump_ready              dump stream handshake
//   dump_data, dump_row, dump_col       dump word and its cell
//   dump_last                           final dump element
//   done                                pulse after CLEAR or DUMP completes
module matrix_buf
   import matbuf_pkg::*;
#(
   parameter  int unsigned DATA_W = 12,
   parameter  int unsigned ROWS   = 8,
   parameter  int unsigned COLS   = 4,
   localparam int unsigned RA_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned CA_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [RA_W-1:0]   wr_row,
   input  logic [CA_W-1:0]   wr_col,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [RA_W-1:0]   rd_row,
   input  logic [CA_W-1:0]   rd_col,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              clr_start,
   input  logic              dump_start,
`ifdef MATBUF_COLMAJOR_EN
   input  logic              dump_colmajor,
`endif
   output logic              busy,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [DATA_W-1:0] dump_data,
   output logic [RA_W-1:0]   dump_row,
   output logic [CA_W-1:0]   dump_col,
   output logic              dump_last,
   output logic              done
);

   localparam int unsigned DEPTH = ROWS * COLS;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW    = DATA_W + RA_W + CA_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state, state_d;
   logic              done_d;
   logic              issue_c, cnt_adv_c;
   logic [RA_W-1:0]   cnt_row;
   logic [CA_W-1:0]   cnt_col;
   logic              row_end_c, col_end_c, cnt_last_c, step_cm_c;
   logic              colmajor;
   logic              issue_end;
   logic              s1_v, s1_ready;
   logic [PW-1:0]     s1_pl, out_pl;
   logic              wr_ok_c, rd_ok_c;
   logic [IDX_W-1:0]  wr_idx_c, rd_idx_c, cnt_idx_c;

   // Address decode; range checks done at 32 bits so ROWS/COLS need not be 2^n.
   assign wr_ok_c   = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
   assign rd_ok_c   = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
   assign wr_idx_c  = IDX_W'(lin_idx(32'(wr_row), 32'(wr_col), COLS));
   assign rd_idx_c  = IDX_W'(lin_idx(32'(rd_row), 32'(rd_col), COLS));
   assign cnt_idx_c = IDX_W'(lin_idx(32'(cnt_row), 32'(cnt_col), COLS));

   assign row_end_c  = (32'(cnt_row) == ROWS - 1);
   assign col_end_c  = (32'(cnt_col) == COLS - 1);
   assign cnt_last_c = row_end_c && col_end_c;
   assign step_cm_c  = colmajor && (state == ST_DUMP);

   assign busy = (state != ST_IDLE);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         done  <= done_d;
      end
   end

   // Next state, sweep stepping and dump read issue
   always_comb begin
      state_d   = state;
      done_d    = 1'b0;
      issue_c   = 1'b0;
      cnt_adv_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (clr_start)       state_d = ST_CLEAR;
            else if (dump_start) state_d = ST_DUMP;
         end
         ST_CLEAR: begin
            cnt_adv_c = 1'b1;
            if (cnt_last_c) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         ST_DUMP: begin
            // Issue only when the read stage is empty or draining this cycle.
            issue_c   = !issue_end && (!s1_v || s1_ready);
            cnt_adv_c = issue_c;
            if (dump_valid && dump_ready && dump_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef MATBUF_COLMAJOR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         colmajor <= 1'b0;
      else if ((state == ST_IDLE) && dump_start && !clr_start)
         colmajor <= dump_colmajor;
   end
`else
   assign colmajor = 1'b0;
`endif

   // Sweep counters; both wrap to 0 after the final cell, and are held at 0 in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_row <= '0;
         cnt_col <= '0;
      end else if (state == ST_IDLE) begin
         cnt_row <= '0;
         cnt_col <= '0;
      end else if (cnt_adv_c) begin
         if (step_cm_c) begin
            if (row_end_c) begin
               cnt_row <= '0;
               cnt_col <= col_end_c ? '0 : cnt_col + CA_W'(1);
            end else begin
               cnt_row <= cnt_row + RA_W'(1);
            end
         end else begin
            if (col_end_c) begin
               cnt_col <= '0;
               cnt_row <= row_end_c ? '0 : cnt_row + RA_W'(1);
            end else begin
               cnt_col <= cnt_col + CA_W'(1);
            end
         end
      end
   end

   // Storage; not reset. CLEAR owns the write port while sweeping.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR)
         mem[cnt_idx_c] <= '0;
      else if (wr_en && wr_ok_c)
         mem[wr_idx_c] <= wr_data;
   end

   // Dump read stage: synchronous read captures the pre-write value of the cell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_pl     <= '0;
         issue_end <= 1'b0;
      end else begin
         if (state == ST_IDLE)
            issue_end <= 1'b0;
         else if (issue_c && cnt_last_c)
            issue_end <= 1'b1;

         if (issue_c) begin
            s1_v  <= 1'b1;
            s1_pl <= {cnt_last_c, cnt_row, cnt_col, mem[cnt_idx_c]};
         end else if (s1_ready) begin
            s1_v <= 1'b0;
         end
      end
   end

   matbuf_skid #(.W(PW)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s1_v),
      .in_ready  (s1_ready),
      .in_data   (s1_pl),
      .out_valid (dump_valid),
      .out_ready (dump_ready),
      .out_data  (out_pl)
   );

   assign {dump_last, dump_row, dump_col, dump_data} = out_pl;

   // Random read port, read-first; out-of-range cells read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if ((state == ST_IDLE) && rd_en) begin
         rd_valid <= 1'b1;
         rd_data  <= rd_ok_c ? mem[rd_idx_c] : '0;
      end else begin
         rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_matrix_buf.sv
// Directed bench for matrix_buf: an 8x4 instance for the main flows and a
// 5x3 instance for non-power-of-two range handling. Expected read and dump
// words are queued when stimulus is applied and popped when the DUT delivers.
module tb_matrix_buf;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 8x4 instance
   logic        wr_en8, rd_en8, rd_valid8, clr8, dump8, busy8, dv8, dr8, dlast8, done8;
   logic [2:0]  wr_row8, rd_row8, drow8;
   logic [1:0]  wr_col8, rd_col8, dcol8;
   logic [11:0] wr_data8, rd_data8, dd8;
   logic        cm8;
   // 5x3 instance
   logic        wr_en5, rd_en5, rd_valid5, clr5, dump5, busy5, dv5, dr5, dlast5, done5;
   logic [2:0]  wr_row5, rd_row5, drow5;
   logic [1:0]  wr_col5, rd_col5, dcol5;
   logic [11:0] wr_data5, rd_data5, dd5;

   matrix_buf #(.DATA_W(12), .ROWS(8), .COLS(4)) u8 (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en8), .wr_row(wr_row8), .wr_col(wr_col8), .wr_data(wr_data8),
      .rd_en(rd_en8), .rd_row(rd_row8), .rd_col(rd_col8),
      .rd_data(rd_data8), .rd_valid(rd_valid8),
      .clr_start(clr8), .dump_start(dump8),
`ifdef MATBUF_COLMAJOR_EN
      .dump_colmajor(cm8),
`endif
      .busy(busy8), .dump_valid(dv8), .dump_ready(dr8), .dump_data(dd8),
      .dump_row(drow8), .dump_col(dcol8), .dump_last(dlast8), .done(done8)
   );

   matrix_buf #(.DATA_W(12), .ROWS(5), .COLS(3)) u5 (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en5), .wr_row(wr_row5), .wr_col(wr_col5), .wr_data(wr_data5),
      .rd_en(rd_en5), .rd_row(rd_row5), .rd_col(rd_col5),
      .rd_data(rd_data5), .rd_valid(rd_valid5),
      .clr_start(clr5), .dump_start(dump5),
`ifdef MATBUF_COLMAJOR_EN
      .dump_colmajor(1'b0),
`endif
      .busy(busy5), .dump_valid(dv5), .dump_ready(dr5), .dump_data(dd5),
      .dump_row(drow5), .dump_col(dcol5), .dump_last(dlast5), .done(done5)
   );

   int tests = 0;
   int fails = 0;
   logic [11:0] rd_q [$];
   logic [17:0] exp_q [$];   // {last,row,col,data}

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // All helpers start and end on a falling edge.
   task automatic wr8(input int r, input int c, input logic [11:0] d);
      wr_en8 = 1'b1; wr_row8 = 3'(r); wr_col8 = 2'(c); wr_data8 = d;
      @(negedge clk);
      wr_en8 = 1'b0;
   endtask

   task automatic wr5(input int r, input int c, input logic [11:0] d);
      wr_en5 = 1'b1; wr_row5 = 3'(r); wr_col5 = 2'(c); wr_data5 = d;
      @(negedge clk);
      wr_en5 = 1'b0;
   endtask

   task automatic rd8(input string tag, input int r, input int c, input logic [11:0] e);
      rd_en8 = 1'b1; rd_row8 = 3'(r); rd_col8 = 2'(c);
      rd_q.push_back(e);
      @(negedge clk);
      rd_en8 = 1'b0;
      chk({tag, "_valid"}, 32'(rd_valid8), 1);
      chk(tag, 32'(rd_data8), 32'(rd_q.pop_front()));
   endtask

   task automatic rd5(input string tag, input int r, input int c, input logic [11:0] e);
      rd_en5 = 1'b1; rd_row5 = 3'(r); rd_col5 = 2'(c);
      rd_q.push_back(e);
      @(negedge clk);
      rd_en5 = 1'b0;
      chk({tag, "_valid"}, 32'(rd_valid5), 1);
      chk(tag, 32'(rd_data5), 32'(rd_q.pop_front()));
   endtask

   // Dump on the 8x4 instance; cells hold 4*r+c. abort_at >= 0 pulls reset
   // while word number abort_at (0-based) is on the output.
   task automatic run_dump(input bit cm, input bit rnd, input int abort_at);
      logic [18:0] cur, prev;
      bit          stall, fin;
      int          got, cyc, first, lastc;
      bit          pat [4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      stall = 1'b0; fin = 1'b0; got = 0; cyc = 0; first = -1; lastc = 0;
      prev = '0;
      exp_q.delete();
      if (cm) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 8; r++)
               exp_q.push_back({(r == 7 && c == 3), 3'(r), 2'(c), 12'(4 * r + c)});
      end else begin
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 4; c++)
               exp_q.push_back({(r == 7 && c == 3), 3'(r), 2'(c), 12'(4 * r + c)});
      end
      cm8 = cm; dump8 = 1'b1;
      @(negedge clk);
      dump8 = 1'b0;
      while (!fin && cyc < 400) begin
         cur = {dv8, dlast8, drow8, dcol8, dd8};
         if (stall) chk("dump_hold", 32'(cur), 32'(prev));
         if (abort_at >= 0 && got == abort_at && dv8) begin
            rst_n = 1'b0;
            #1;
            chk("abort_dump_outs", 32'({dv8, dlast8, drow8, dcol8, dd8}), 0);
            chk("abort_other_outs", 32'({busy8, done8, rd_valid8, rd_data8}), 0);
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               chk("abort_no_done", 32'({busy8, done8, dv8}), 0);
            end
            return;
         end
         dr8 = rnd ? ((cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1))) : 1'b1;
         if (dv8 && dr8) begin
            if (exp_q.size() == 0) chk("dump_extra_word", 32'(cur), 0);
            else chk("dump_word", 32'(cur[17:0]), 32'(exp_q.pop_front()));
            if (first < 0) first = cyc;
            lastc = cyc;
            got++;
            if (dlast8) fin = 1'b1;
         end
         stall = dv8 && !dr8;
         prev  = cur;
         @(negedge clk);
         cyc++;
      end
      dr8 = 1'b1;
      chk("dump_finished", 32'(fin), 1);
      chk("dump_count", got, 32);
      if (!rnd) chk("dump_no_bubble", lastc - first, 31);
      chk("dump_done_idle", 32'({busy8, done8, dv8}), 32'(3'b010));
      @(negedge clk);
      chk("dump_done_pulse", 32'(done8), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  sawv;
      rst_n = 1'b0;
      {wr_en8, rd_en8, clr8, dump8, cm8, wr_en5, rd_en5, clr5, dump5} = '0;
      {wr_row8, wr_col8, wr_data8, rd_row8, rd_col8} = '0;
      {wr_row5, wr_col5, wr_data5, rd_row5, rd_col5} = '0;
      dr8 = 1'b1; dr5 = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_dump_outs", 32'({dv8, dlast8, drow8, dcol8, dd8}), 0);
      chk("reset_other_outs", 32'({busy8, done8, rd_valid8, rd_data8}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: clear sweep, then every cell reads zero
      clr8 = 1'b1;
      @(negedge clk);
      clr8 = 1'b0;
      n = 0;
      while (busy8 && n < 100) begin n++; @(negedge clk); end
      chk("clr_busy_cycles", n, 32);
      chk("clr_done", 32'(done8), 1);
      @(negedge clk);
      chk("clr_done_pulse", 32'(done8), 0);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++)
            rd8("clr_cell", r, c, 12'h000);

      // 2: signed extremes, read-first, read data hold
      wr8(2, 3, 12'h7FF);
      wr8(7, 0, 12'h800);
      rd8("rd_pos_max", 2, 3, 12'h7FF);
      rd8("rd_neg_min", 7, 0, 12'h800);
      wr_en8 = 1'b1; wr_row8 = 3'd2; wr_col8 = 2'd3; wr_data8 = 12'h123;
      rd_en8 = 1'b1; rd_row8 = 3'd2; rd_col8 = 2'd3;
      rd_q.push_back(12'h7FF);
      @(negedge clk);
      wr_en8 = 1'b0; rd_en8 = 1'b0;
      chk("rd_first_valid", 32'(rd_valid8), 1);
      chk("rd_first_old", 32'(rd_data8), 32'(rd_q.pop_front()));
      rd8("rd_after_wr", 2, 3, 12'h123);
      @(negedge clk);
      chk("rd_pulse_end", 32'(rd_valid8), 0);
      chk("rd_data_hold", 32'(rd_data8), 32'h123);

      // 3: fill 4*r+c, dump with ready held high
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 4; c++)
            wr8(r, c, 12'(4 * r + c));
      run_dump(1'b0, 1'b0, -1);

      // 4: dump with back-pressure
      run_dump(1'b0, 1'b1, -1);

      // 6: reset while the 10th word is presented, then a clean dump again
      run_dump(1'b0, 1'b0, 9);
      run_dump(1'b0, 1'b0, -1);
`ifdef MATBUF_COLMAJOR_EN
      run_dump(1'b1, 1'b0, -1);
`endif

      // 5: 5x3 range handling and start priority
      clr5 = 1'b1;
      @(negedge clk);
      clr5 = 1'b0;
      n = 0;
      while (busy5 && n < 100) begin n++; @(negedge clk); end
      chk("clr5_busy_cycles", n, 15);
      chk("clr5_done", 32'(done5), 1);
      wr5(6, 0, 12'h111);
      wr5(1, 3, 12'h555);
      wr5(4, 2, 12'h3AB);
      rd5("oor_row_no_alias", 0, 2, 12'h000);
      rd5("oor_col_no_alias", 2, 0, 12'h000);
      wr5(2, 0, 12'h0AA);
      rd5("oor_rd_col", 1, 3, 12'h000);
      rd5("oor_rd_row6", 6, 0, 12'h000);
      rd5("oor_rd_row5", 5, 0, 12'h000);
      rd5("rd5_last_cell", 4, 2, 12'h3AB);
      clr5 = 1'b1; dump5 = 1'b1;
      @(negedge clk);
      clr5 = 1'b0; dump5 = 1'b0;
      n = 0; sawv = 1'b0;
      while (busy5 && n < 100) begin
         sawv = sawv | dv5;
         n++;
         @(negedge clk);
      end
      chk("both_start_clear_len", n, 15);
      chk("both_start_no_dump", 32'(sawv), 0);
      chk("both_start_done", 32'(done5), 1);
      rd5("both_start_cleared", 4, 2, 12'h000);
      rd5("both_start_cleared2", 2, 0, 12'h000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
